// File: rtl/ldpc_simd_cnu_acc.sv
// SIMD min-sum check-node accumulator: per lane min1/min2/argmin/sign parity over up to MAX_DEG beats.
// Optional LDPC_OFFSET_EN applies offset-min-sum correction to the presented minima.
module ldpc_simd_cnu_acc #(
    parameter int Q       = 8,
    parameter int SIMD    = 4,
    parameter int MAX_DEG = 16,
    parameter int SAT_MAX = 63,
    parameter int OFFSET  = 1,
    localparam int IDXW   = $clog2(MAX_DEG)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [Q*SIMD-1:0]      in_data_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [Q*SIMD-1:0]      out_min1_o,
    output logic [Q*SIMD-1:0]      out_min2_o,
    output logic [IDXW*SIMD-1:0]   out_idx_o,
    output logic [SIMD-1:0]        out_sign_o,
    output logic [IDXW:0]          out_deg_o,
    output logic                   out_err_o
);
    localparam int DW = IDXW + 1;
    localparam int QW = Q + 1;
    localparam logic [Q-1:0]  SAT     = Q'(SAT_MAX);
    localparam logic [QW-1:0] SAT_W   = QW'(SAT_MAX);
    localparam logic [DW-1:0] DEG_LIM = DW'(MAX_DEG - 1);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t                     state_q;
    logic                       in_ready_q, out_valid_q;
    logic [SIMD-1:0][Q-1:0]     x, mag, min1_q, min2_q, min1_d, min2_d;
    logic [SIMD-1:0][Q-1:0]     res_min1_q, res_min2_q, res_min1_d, res_min2_d;
    logic [SIMD-1:0][QW-1:0]    absx;
    logic [SIMD-1:0][IDXW-1:0]  idx_q, idx_d, res_idx_q;
    logic [SIMD-1:0]            sign_q, sign_d, res_sign_q;
    logic [DW-1:0]              deg_q, deg_d, cur_deg, res_deg_q;
    logic                       res_err_q, first, accept, ovf, close;

    function automatic logic [Q-1:0] apply_ofs(input logic [Q-1:0] v);
`ifdef LDPC_OFFSET_EN
        return (v > Q'(OFFSET)) ? v - Q'(OFFSET) : '0;
`else
        return v;
`endif
    endfunction

    always_comb begin
        first   = (state_q == IDLE);
        accept  = in_valid_i && in_ready_q;
        cur_deg = first ? '0 : deg_q;
        deg_d   = cur_deg + DW'(1);
        // Hitting the last legal index without in_last closes the node as an error.
        ovf     = !in_last_i && (cur_deg == DEG_LIM);
        close   = accept && (in_last_i || ovf);
        for (int l = 0; l < SIMD; l++) begin
            x[l]    = in_data_i[l*Q +: Q];
            absx[l] = x[l][Q-1] ? -{x[l][Q-1], x[l]} : {x[l][Q-1], x[l]};
            mag[l]  = (absx[l] > SAT_W) ? SAT : absx[l][Q-1:0];
            min1_d[l] = min1_q[l];
            min2_d[l] = min2_q[l];
            idx_d[l]  = idx_q[l];
            if (first) begin
                min1_d[l] = mag[l];
                min2_d[l] = SAT;
                idx_d[l]  = '0;
            end else if (mag[l] < min1_q[l]) begin
                min2_d[l] = min1_q[l];
                min1_d[l] = mag[l];
                idx_d[l]  = cur_deg[IDXW-1:0];
            end else if (mag[l] < min2_q[l]) begin
                min2_d[l] = mag[l];
            end
            sign_d[l]     = first ? x[l][Q-1] : (sign_q[l] ^ x[l][Q-1]);
            res_min1_d[l] = apply_ofs(min1_d[l]);
            res_min2_d[l] = apply_ofs(min2_d[l]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            min1_q      <= '0;
            min2_q      <= '0;
            idx_q       <= '0;
            sign_q      <= '0;
            deg_q       <= '0;
            res_min1_q  <= '0;
            res_min2_q  <= '0;
            res_idx_q   <= '0;
            res_sign_q  <= '0;
            res_deg_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        min1_q <= min1_d;
                        min2_q <= min2_d;
                        idx_q  <= idx_d;
                        sign_q <= sign_d;
                        deg_q  <= deg_d;
                        if (close) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            res_min1_q  <= res_min1_d;
                            res_min2_q  <= res_min2_d;
                            res_idx_q   <= idx_d;
                            res_sign_q  <= sign_d;
                            res_deg_q   <= deg_d;
                            res_err_q   <= ovf;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_min1_o  = res_min1_q;
    assign out_min2_o  = res_min2_q;
    assign out_idx_o   = res_idx_q;
    assign out_sign_o  = res_sign_q;
    assign out_deg_o   = res_deg_q;
    assign out_err_o   = res_err_q;

endmodule
